icache_direct: RTL

- Blocking, direct-mapped, one-word-per-line instruction cache.
- Sits between the core's instruction port (physical address after mmu) and the instruction port of cpu_axi_interface.
- Both sides use the same sram-like handshake (req/wr/size/addr/wdata/rdata/addr_ok/data_ok).
- Serves hits without memory traffic; forwards misses, uncached reads and writes to memory.

---
 rtl/icache_direct_if.sv | 17 +
 rtl/icache_direct.sv | 131 +++++++++++++
 2 files changed

// File: rtl/icache_direct_if.sv
// SRAM-like request/response bundle shared by the core side and the memory side of the cache.
interface icache_direct_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        uncached;
    logic [31:0] rdata;
    logic        addr_ok;
    logic        data_ok;

    modport master (output req, wr, size, addr, wdata, uncached,
                    input  rdata, addr_ok, data_ok);
    modport slave  (input  req, wr, size, addr, wdata, uncached,
                    output rdata, addr_ok, data_ok);
endinterface

// File: rtl/icache_direct.sv
// Blocking direct-mapped instruction cache, one 32-bit word per line.
// Hits are served from the arrays; misses, uncached reads and writes go to memory.
//   state    | meaning
//   S_IDLE   | ready, accepts a request and reads the arrays
//   S_LOOKUP | tag compare on registered array outputs
//   S_MISS   | memory request held until mem addr_ok
//   S_WAIT   | waiting for mem data_ok, then refill or invalidate
module icache_direct #(
    parameter int INDEX_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    icache_direct_if.slave  cpu,
    icache_direct_if.master mem
);
    localparam int LINES = 1 << INDEX_W;
    localparam int TAG_W = 30 - INDEX_W;

    typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_MISS, S_WAIT} state_t;

    state_t state, state_nxt;

    logic [31:0] lat_addr;
    logic        lat_wr;
    logic [1:0]  lat_size;
    logic [31:0] lat_wdata;
    logic        lat_uncached;

    logic [LINES-1:0] valid;
    logic [TAG_W-1:0] tag_mem  [LINES];
    logic [31:0]      data_mem [LINES];
    logic             valid_q;
    logic [TAG_W-1:0] tag_q;
    logic [31:0]      data_q;

    logic [INDEX_W-1:0] idx, cpu_idx;
    logic accept, hit, cached_rd, fill;

    assign idx       = lat_addr[INDEX_W+1:2];
    assign cpu_idx   = cpu.addr[INDEX_W+1:2];
    assign accept    = (state == S_IDLE) && cpu.req;
    assign hit       = valid_q && (tag_q == lat_addr[31:INDEX_W+2]);
    assign cached_rd = !lat_wr && !lat_uncached;
    assign fill      = (state == S_WAIT) && mem.data_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            valid   <= '0;
            valid_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                lat_addr     <= cpu.addr;
                lat_wr       <= cpu.wr;
                lat_size     <= cpu.size;
                lat_wdata    <= cpu.wdata;
                lat_uncached <= cpu.uncached;
                valid_q      <= valid[cpu_idx];
            end
            // Writes only invalidate; the line is never write-allocated.
            if (fill && cached_rd)
                valid[idx] <= 1'b1;
            else if (fill && lat_wr)
                valid[idx] <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && fill && cached_rd) begin
            tag_mem[idx]  <= lat_addr[31:INDEX_W+2];
            data_mem[idx] <= mem.rdata;
        end
        if (!rst && accept) begin
            tag_q  <= tag_mem[cpu_idx];
            data_q <= data_mem[cpu_idx];
        end
    end

    assign mem.addr     = cached_rd ? {lat_addr[31:2], 2'b00} : lat_addr;
    assign mem.size     = cached_rd ? 2'd2 : lat_size;
    assign mem.wdata    = lat_wdata;
    assign mem.uncached = lat_uncached;

    always_comb begin
        state_nxt   = state;
        cpu.addr_ok = 1'b0;
        cpu.data_ok = 1'b0;
        cpu.rdata   = 32'h0;
        mem.req     = 1'b0;
        mem.wr      = 1'b0;
        case (state)
            S_IDLE: begin
                cpu.addr_ok = 1'b1;
                if (cpu.req)
                    state_nxt = (!cpu.wr && !cpu.uncached) ? S_LOOKUP : S_MISS;
            end
            S_LOOKUP: begin
                if (hit) begin
                    cpu.data_ok = 1'b1;
                    cpu.rdata   = data_q;
                    state_nxt   = S_IDLE;
                end else begin
                    state_nxt = S_MISS;
                end
            end
            S_MISS: begin
                mem.req = 1'b1;
                mem.wr  = lat_wr;
                if (mem.addr_ok)
                    state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (mem.data_ok) begin
                    cpu.data_ok = 1'b1;
                    cpu.rdata   = mem.rdata;
                    state_nxt   = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        // Reset abandons any transaction; nothing is accepted or completed meanwhile.
        if (rst) begin
            cpu.addr_ok = 1'b0;
            cpu.data_ok = 1'b0;
            cpu.rdata   = 32'h0;
            mem.req     = 1'b0;
            mem.wr      = 1'b0;
        end
    end
endmodule
